pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
Parametrised inter-stage pipeline buffer that replaces the fixed fetch/decode, decode/execute, execute/memory and memory/writeback buffers with one generic block. It carries a control bundle and a data bundle, and uses a valid/ready handshake with a two-entry skid. This lets a downstream stall back-pressure upstream without losing an instruction. It adds a synchronous flush, with bubble insertion, and saturating stall and flush counters for pipeline debug.

Parameters:
CTRL_W, 16, width of control bundle (WB/Mem/Ex signals)
DATA_W, 96, width of data bundle (pc, register data, immediate, register ids)
NOP_CTRL, 0, control value driven whenever o_valid=0 (bubble); must deassert all write enables
CNT_W, 16, width of each debug counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; discards all held and incoming entries
i_valid  input  1  upstream entry present
o_ready  output  1  buffer can accept an entry this cycle
i_ctrl  input  CTRL_W  upstream control bundle
i_data  input  DATA_W  upstream data bundle
o_valid  output  1  downstream entry present
i_ready  input  1  downstream accepts entry this cycle
o_ctrl  output  CTRL_W  control bundle of head entry, or NOP_CTRL when o_valid=0
o_data  output  DATA_W  data bundle of head entry (value is don't-care when o_valid=0)
o_occupancy  output  2  entries held: 0, 1 or 2
o_stall_cnt  output  CNT_W  saturating count of stalled cycles
o_flush_cnt  output  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (rst=0, asynchronous) sets the following, all held while rst=0:
  - state EMPTY; o_valid=0, o_ready=1, o_occupancy=0
  - o_ctrl=NOP_CTRL, o_data=0
  - both counters 0
- Storage: head register (drives outputs) plus skid register. FIFO order is strict; no reordering or duplication.
- Define acc = i_valid & o_ready and pop = o_valid & i_ready.
- o_ready is driven from a register: o_ready = (state != FULL). It never depends combinationally on i_ready.
- States and transitions (no flush):
  - EMPTY: acc -> BUSY; the head loads the input, so o_valid rises the next cycle (latency 1).
  - BUSY: acc & pop -> BUSY, head reloads from input. acc & !pop -> FULL, skid loads input. !acc & pop -> EMPTY. Otherwise hold.
  - FULL: i_valid is ignored (o_ready=0). pop -> BUSY, head loads skid. !pop -> hold both.
- Flush has the highest priority in the cycle it is sampled high:
  - next state EMPTY, head and skid invalidated, and any same-cycle acc is discarded.
  - pop in that cycle still completes downstream; the buffer does not retract a consumed entry.
  - o_ready=1 from the next cycle on.
- Bubble: whenever o_valid=0, o_ctrl=NOP_CTRL. o_data holds its last value and the verifier must not check it.
- o_stall_cnt increments in every cycle with o_valid=1 & i_ready=0. It saturates at all-ones and never wraps.
- o_flush_cnt increments in every cycle with flush=1, regardless of occupancy, and saturates.
- Counters clear only on reset.
- Reset asserted mid-transfer drops all entries immediately. The first acc after reset release behaves as from EMPTY.
- Throughput: one entry per cycle sustained when i_ready=1 continuously; no bubbles are inserted by the buffer itself.

Test Plan:
1. Streaming: i_valid=1, i_ready=1, i_data=1,2,3,4 on consecutive cycles -> o_data=1,2,3,4 one cycle later each. o_occupancy stays 1, o_stall_cnt=0.
2. Back-pressure: stream 10,11,12, then drop i_ready for 3 cycles.
   - o_occupancy reaches 2 and o_ready=0 while i_valid stays 1.
   - On i_ready=1, o_data=11 then 12 in order, with no loss.
   - o_stall_cnt=3.
3. Flush while FULL: occupancy 2 with i_valid=1 and data 0x55 presented, flush=1 for 1 cycle.
   - Next cycle o_valid=0, o_ctrl=NOP_CTRL, o_occupancy=0, o_ready=1, o_flush_cnt=1.
   - 0x55 is never output.
4. Flush with simultaneous pop: occupancy 1, i_ready=1, flush=1 -> the head entry is consumed that cycle and nothing further is emitted.
5. Counter saturation: CNT_W=4, hold o_valid=1 & i_ready=0 for 20 cycles -> o_stall_cnt=15 and stays 15.
6. Async reset mid-operation: occupancy 2, pull rst low between clock edges.
   - Outputs go immediately to o_valid=0, o_ctrl=NOP_CTRL, o_occupancy=0, counters 0.
   - After release, entry 0x7 emerges after 1 cycle.

Source files
------------

// File: rtl/pipe_stage_buf_if.sv
// Purpose: valid/ready pipeline channel around one pipe_stage_buf.
//   Upstream side : i_valid, i_ctrl, i_data in; o_ready out.
//   Downstream    : o_valid, o_ctrl, o_data out; i_ready in.
//   slave  modport -> the buffer itself.
//   master modport -> whatever drives and consumes the buffer (stages, bench).
interface pipe_stage_buf_if #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 96
);
    logic              i_valid;
    logic              o_ready;
    logic [CTRL_W-1:0] i_ctrl;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;

    modport slave (
        input  i_valid, i_ctrl, i_data, i_ready,
        output o_ready, o_valid, o_ctrl, o_data
    );

    modport master (
        output i_valid, i_ctrl, i_data, i_ready,
        input  o_ready, o_valid, o_ctrl, o_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Purpose: generic inter-stage pipeline buffer with a two-entry skid
//   (head + skid register), synchronous flush with bubble insertion and
//   saturating stall/flush debug counters.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   flush        synchronous flush, drops held and incoming entries
//   bus          valid/ready channel (slave side)
//   o_occupancy  entries currently held (0..2)
//   o_stall_cnt  saturating count of cycles with o_valid & !i_ready
//   o_flush_cnt  saturating count of cycles with flush high
module pipe_stage_buf #(
    parameter int unsigned        CTRL_W   = 16,
    parameter int unsigned        DATA_W   = 96,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_buf_if.slave      bus,
    output logic [1:0]           o_occupancy,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [1:0]         occ_q, occ_d;
    logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0]  head_data_q, head_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic acc;
    logic pop;

    // Handshakes are judged against the registered outputs only.
    assign acc = bus.i_valid & ready_q;
    assign pop = valid_q & bus.i_ready;

    // Next-state, storage moves and registered-output decode.
    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // A same-cycle pop still completes downstream; nothing is kept.
            state_d     = ST_EMPTY;
            head_ctrl_d = NOP_CTRL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d     = ST_BUSY;
                        head_ctrl_d = bus.i_ctrl;
                        head_data_d = bus.i_data;
                    end
                end
                ST_BUSY: begin
                    if (acc && pop) begin
                        head_ctrl_d = bus.i_ctrl;
                        head_data_d = bus.i_data;
                    end else if (acc) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = bus.i_ctrl;
                        skid_data_d = bus.i_data;
                    end else if (pop) begin
                        state_d     = ST_EMPTY;
                        head_ctrl_d = NOP_CTRL;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d     = ST_BUSY;
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    head_ctrl_d = NOP_CTRL;
                end
            endcase
        end

        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_FULL);
        case (state_d)
            ST_BUSY: occ_d = 2'd1;
            ST_FULL: occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // Saturating debug counters.
    always_comb begin
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        if (valid_q && !bus.i_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            occ_q       <= 2'd0;
            head_ctrl_q <= NOP_CTRL;
            head_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            occ_q       <= occ_d;
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.o_valid  = valid_q;
    assign bus.o_ready  = ready_q;
    assign bus.o_ctrl   = head_ctrl_q;
    assign bus.o_data   = head_data_q;
    assign o_occupancy  = occ_q;
    assign o_stall_cnt  = stall_q;
    assign o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_buf;

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned DATA_W = 96;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CTRL_W-1:0] NOP = 16'h8001;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_stage_buf_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

    pipe_stage_buf #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_CTRL(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .o_occupancy(occ), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just an ordered queue of at most 2.
    ent_t q[$];
    int   m_stall = 0;
    int   m_flush = 0;
    bit   m_acc, m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_acc = bus.i_valid && (q.size() < 2);
            m_pop = (q.size() > 0) && bus.i_ready;
            if ((q.size() > 0) && !bus.i_ready && (m_stall < CMAX)) m_stall++;
            if (flush && (m_flush < CMAX)) m_flush++;
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_acc) q.push_back(ent_t'{c: bus.i_ctrl, d: bus.i_data});
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        chk("valid", 128'(bus.o_valid), 128'(q.size() > 0));
        chk("ready", 128'(bus.o_ready), 128'(q.size() < 2));
        chk("occupancy", 128'(occ), 128'(q.size()));
        chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        chk("flush_cnt", 128'(flush_cnt), 128'(m_flush));
        if (q.size() > 0) begin
            chk("ctrl", 128'(bus.o_ctrl), 128'(q[0].c));
            chk("data", 128'(bus.o_data), 128'(q[0].d));
        end else begin
            chk("ctrl_bubble", 128'(bus.o_ctrl), 128'(NOP));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic f, input logic [DATA_W-1:0] d);
        bus.i_valid = v;
        bus.i_ready = r;
        flush       = f;
        bus.i_data  = d;
        bus.i_ctrl  = CTRL_W'(d) ^ 16'h0f0f;
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", 128'(bus.o_valid), 128'(0));
        chk("rst_ready", 128'(bus.o_ready), 128'(1));
        chk("rst_occ", 128'(occ), 128'(0));
        chk("rst_ctrl", 128'(bus.o_ctrl), 128'(NOP));
        chk("rst_stall", 128'(stall_cnt), 128'(0));
        chk("rst_flush", 128'(flush_cnt), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        drive(0, 0, 0, '0);
        #1;
        check_reset_vals();
        chk("rst_data", 128'(bus.o_data), 128'(0));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, '0);
        do_reset();

        // Streaming: 1..4 each emerges one cycle later, occupancy stays 1.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, DATA_W'(i));
            step();
            chk("stream_data", 128'(bus.o_data), 128'(i));
            chk("stream_occ", 128'(occ), 128'(1));
        end
        drive(0, 1, 0, '0);
        step();
        chk("stream_stall", 128'(stall_cnt), 128'(0));

        // Back-pressure: 10,11,12 then three stalled cycles.
        do_reset();
        drive(1, 1, 0, DATA_W'(10)); step();
        drive(1, 1, 0, DATA_W'(11)); step();
        drive(1, 0, 0, DATA_W'(12)); step();
        drive(1, 0, 0, DATA_W'(13)); step();
        step();
        chk("bp_occ", 128'(occ), 128'(2));
        chk("bp_ready", 128'(bus.o_ready), 128'(0));
        chk("bp_stall", 128'(stall_cnt), 128'(3));
        chk("bp_head", 128'(bus.o_data), 128'(11));
        drive(0, 1, 0, '0); step();
        chk("bp_next", 128'(bus.o_data), 128'(12));
        step();
        chk("bp_drain", 128'(bus.o_valid), 128'(0));

        // Flush while full with 0x55 presented.
        do_reset();
        drive(1, 0, 0, DATA_W'(1)); step();
        drive(1, 0, 0, DATA_W'(2)); step();
        chk("fl_full", 128'(occ), 128'(2));
        drive(1, 0, 1, DATA_W'('h55)); step();
        drive(0, 1, 0, '0);
        chk("fl_valid", 128'(bus.o_valid), 128'(0));
        chk("fl_ctrl", 128'(bus.o_ctrl), 128'(NOP));
        chk("fl_occ", 128'(occ), 128'(0));
        chk("fl_ready", 128'(bus.o_ready), 128'(1));
        chk("fl_cnt", 128'(flush_cnt), 128'(1));
        step();
        chk("fl_no55", 128'(bus.o_valid), 128'(0));

        // Flush with simultaneous pop.
        do_reset();
        drive(1, 0, 0, DATA_W'(3)); step();
        chk("fp_head", 128'(bus.o_data), 128'(3));
        drive(0, 1, 1, '0); step();
        drive(0, 1, 0, '0);
        chk("fp_valid", 128'(bus.o_valid), 128'(0));
        step();
        chk("fp_valid2", 128'(bus.o_valid), 128'(0));

        // Stall counter saturation.
        do_reset();
        drive(1, 0, 0, DATA_W'(9)); step();
        drive(0, 0, 0, '0);
        repeat (20) step();
        chk("sat_stall", 128'(stall_cnt), 128'(15));
        step();
        chk("sat_hold", 128'(stall_cnt), 128'(15));

        // Async reset mid-operation, then first entry after release.
        do_reset();
        drive(1, 0, 0, DATA_W'(4)); step();
        drive(1, 0, 0, DATA_W'(5)); step();
        chk("ar_full", 128'(occ), 128'(2));
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive(1, 1, 0, DATA_W'(7));
        step();
        drive(0, 1, 0, '0);
        chk("ar_valid", 128'(bus.o_valid), 128'(1));
        chk("ar_data", 128'(bus.o_data), 128'(7));
        step();

        // Randomized traffic with varying ready/flush densities.
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                bus.i_valid = ($urandom_range(0, 3) != 0);
                bus.i_ready = ($urandom_range(0, 7) < (seg + 2));
                flush       = ($urandom_range(0, 39) == 0);
                bus.i_ctrl  = CTRL_W'($urandom);
                bus.i_data  = {$urandom, $urandom, $urandom};
                step();
            end
        end
        drive(0, 1, 0, '0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
